// File: rtl/game_round_sequencer.sv
// rtl/game_round_sequencer.sv - round/attempt/score sequencer for the guessing game
// Owns the 1 s timebase, countdowns, button sync/edge detect and the VGA screen select.
module game_round_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SHOW_SECS  = 3,
    parameter int INPUT_SECS = 10,
    parameter int MAX_TRIES  = 3,
    parameter int ROUNDS     = 5,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               button_i,
    input  logic               guess_ok_i,
    output logic [2:0]         screen_o,
    output logic [3:0]         sec_left_o,
    output logic [2:0]         tries_left_o,
    output logic [3:0]         round_num_o,
    output logic [SCORE_W-1:0] score_o,
    output logic               load_secret_o,
    output logic               busy_o,
    output logic               game_over_o
);

    localparam int                PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0]        SHOW_N    = 4'(SHOW_SECS);
    localparam logic [3:0]        INPUT_N   = 4'(INPUT_SECS);
    localparam logic [2:0]        TRIES_N   = 3'(MAX_TRIES);
    localparam logic [3:0]        ROUNDS_N  = 4'(ROUNDS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHOW  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [3:0]         sec_q, sec_d;
    logic [2:0]         tries_q, tries_d;
    logic [3:0]         round_q, round_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               load_q, load_d;
    logic [2:0]         screen_q, screen_d;
    logic               busy_q, busy_d;
    logic               over_q, over_d;
    logic               sync1_q, sync2_q, sync3_q;

    logic tick;
    logic last_tick;
    logic press;
    logic miss;

    assign tick      = (presc_q == PRESC_MAX);
    assign last_tick = tick && (sec_q == 4'd1);
    assign press     = sync2_q & ~sync3_q;

    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        sec_d    = sec_q;
        tries_d  = tries_q;
        round_d  = round_q;
        score_d  = score_q;
        load_d   = 1'b0;
        miss     = 1'b0;
        // Untimed states hold sec_left at 0, so the decrement never wraps there.
        if (tick && (sec_q != 4'd0)) begin
            sec_d = sec_q - 4'd1;
        end
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_i) begin
                    state_d = S_SHOW;
                    presc_d = '0;
                    sec_d   = SHOW_N;
                    tries_d = TRIES_N;
                    round_d = 4'd1;
                    score_d = '0;
                    load_d  = 1'b1;
                end
            end
            S_SHOW: begin
                if (last_tick) begin
                    state_d = S_WAIT;
                    presc_d = '0;
                    sec_d   = INPUT_N;
                end
            end
            S_WAIT: begin
                if (press) begin
                    state_d = S_CHECK;
                    presc_d = '0;
                    sec_d   = 4'd0;
                end else if (last_tick) begin
                    miss = 1'b1;
                end
            end
            S_CHECK: begin
                if (guess_ok_i) begin
                    state_d = S_WIN;
                    presc_d = '0;
                    sec_d   = SHOW_N;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else begin
                    miss = 1'b1;
                end
            end
            S_WIN, S_LOSE: begin
                if (last_tick) begin
                    presc_d = '0;
                    if (round_q == ROUNDS_N) begin
                        state_d = S_OVER;
                        sec_d   = 4'd0;
                    end else begin
                        state_d = S_SHOW;
                        sec_d   = SHOW_N;
                        round_d = round_q + 4'd1;
                        tries_d = TRIES_N;
                        load_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
                sec_d   = 4'd0;
            end
        endcase
        // A timeout and a wrong compare share the same consequence.
        if (miss) begin
            presc_d = '0;
            tries_d = tries_q - 3'd1;
            if (tries_q <= 3'd1) begin
                state_d = S_LOSE;
                sec_d   = SHOW_N;
            end else begin
                state_d = S_WAIT;
                sec_d   = INPUT_N;
            end
        end
    end

    always_comb begin
        screen_d = 3'b000;
        busy_d   = 1'b1;
        over_d   = 1'b0;
        case (state_d)
            S_IDLE:         busy_d   = 1'b0;
            S_SHOW:         screen_d = 3'b001;
            S_WAIT, S_CHECK: screen_d = 3'b010;
            S_WIN:          screen_d = 3'b011;
            S_LOSE:         screen_d = 3'b100;
            S_OVER: begin
                screen_d = 3'b101;
                busy_d   = 1'b0;
                over_d   = 1'b1;
            end
            default:        busy_d   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            sec_q    <= 4'd0;
            tries_q  <= TRIES_N;
            round_q  <= 4'd0;
            score_q  <= '0;
            load_q   <= 1'b0;
            screen_q <= 3'b000;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            tries_q  <= tries_d;
            round_q  <= round_d;
            score_q  <= score_d;
            load_q   <= load_d;
            screen_q <= screen_d;
            busy_q   <= busy_d;
            over_q   <= over_d;
            sync1_q  <= button_i;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
        end
    end

    assign screen_o      = screen_q;
    assign sec_left_o    = sec_q;
    assign tries_left_o  = tries_q;
    assign round_num_o   = round_q;
    assign score_o       = score_q;
    assign load_secret_o = load_q;
    assign busy_o        = busy_q;
    assign game_over_o   = over_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// tb/tb_game_round_sequencer.sv - scoreboard bench for game_round_sequencer
// Expected screen transitions are queued as stimulus is driven and checked as the DUT changes screen.
module tb_game_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic       button_i;
    logic       guess_ok_i;
    logic [2:0] screen_o;
    logic [3:0] sec_left_o;
    logic [2:0] tries_left_o;
    logic [3:0] round_num_o;
    logic [3:0] score_o;
    logic       load_secret_o;
    logic       busy_o;
    logic       game_over_o;

    game_round_sequencer #(.CLK_HZ(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .button_i      (button_i),
        .guess_ok_i    (guess_ok_i),
        .screen_o      (screen_o),
        .sec_left_o    (sec_left_o),
        .tries_left_o  (tries_left_o),
        .round_num_o   (round_num_o),
        .score_o       (score_o),
        .load_secret_o (load_secret_o),
        .busy_o        (busy_o),
        .game_over_o   (game_over_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] scr;
        int         dur;
        int         sec;
        int         tries;
        int         rnd;
        int         score;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] scr, input int dur, input int sec,
                            input int tries, input int rnd, input int score);
        exp_t e;
        e.scr = scr; e.dur = dur; e.sec = sec;
        e.tries = tries; e.rnd = rnd; e.score = score;
        exp_q.push_back(e);
    endtask

    // Screen-change monitor: pops one expectation per observed transition.
    logic       mon_en = 1'b0;
    logic       mon_armed = 1'b0;
    logic [2:0] mon_prev;
    int         cyc = 0;
    int         last_chg = 0;
    exp_t       mon_e;

    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            mon_armed = 1'b0;
        end else if (!mon_armed) begin
            mon_prev  = screen_o;
            last_chg  = cyc;
            mon_armed = 1'b1;
        end else begin
            if (load_secret_o)
                check("load_at_show_entry", int'(screen_o == 3'd1 && mon_prev != 3'd1), 1);
            if (screen_o != mon_prev) begin
                check("sb_entry_available", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("sb_screen", screen_o, mon_e.scr);
                    if (mon_e.dur >= 0) check("sb_prev_duration", cyc - last_chg, mon_e.dur);
                    check("sb_sec_left", sec_left_o, mon_e.sec);
                    check("sb_tries_left", tries_left_o, mon_e.tries);
                    check("sb_round_num", round_num_o, mon_e.rnd);
                    check("sb_score", score_o, mon_e.score);
                    check("sb_busy", busy_o, int'(mon_e.scr != 3'd0 && mon_e.scr != 3'd5));
                    check("sb_game_over", game_over_o, int'(mon_e.scr == 3'd5));
                    if (mon_e.scr == 3'd1) check("sb_load_secret", load_secret_o, 1);
                end
                mon_prev = screen_o;
                last_chg = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_screen(input logic [2:0] scr, input int budget);
        int n;
        n = 0;
        while (screen_o !== scr && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("reach_screen", screen_o, scr);
    endtask

    task automatic check_reset_vals();
        check("rst_screen", screen_o, 0);
        check("rst_sec_left", sec_left_o, 0);
        check("rst_tries_left", tries_left_o, 3);
        check("rst_round_num", round_num_o, 0);
        check("rst_score", score_o, 0);
        check("rst_load_secret", load_secret_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_game_over", game_over_o, 0);
    endtask

    // Called at the negedge where WAIT_IN was first observed.
    task automatic win_round(input int rnd, input int score_after, input bit last);
        button_i   = 1'b1;
        guess_ok_i = 1'b1;
        push_exp(3'd3, 4, 3, 3, rnd, score_after);
        if (last) begin
            push_exp(3'd5, 30, 0, 3, rnd, score_after);
        end else begin
            push_exp(3'd1, 30, 3, 3, rnd + 1, score_after);
            push_exp(3'd2, 30, 10, 3, rnd + 1, score_after);
        end
        step(4);
        button_i = 1'b0;
        wait_screen(last ? 3'd5 : 3'd2, 200);
    endtask

    task automatic wrong_press(input int exp_tries);
        button_i   = 1'b1;
        guess_ok_i = 1'b0;
        step(3);
        check("check_screen", screen_o, 2);
        check("check_sec_left", sec_left_o, 0);
        step(1);
        check("miss_tries_left", tries_left_o, exp_tries);
        if (exp_tries > 0) check("miss_sec_reload", sec_left_o, 10);
        button_i = 1'b0;
        step(2);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; button_i = 1'b0; guess_ok_i = 1'b0;
        step(2);
        check_reset_vals();
        reset  = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Game 1, round 1: start, SHOW countdown, correct guess.
        start_i = 1'b1;
        push_exp(3'd1, -1, 3, 3, 1, 0);
        push_exp(3'd2, 30, 10, 3, 1, 0);
        step(1);
        start_i = 1'b0;
        check("load_first_show", load_secret_o, 1);
        check("show_sec3", sec_left_o, 3);
        step(1);
        check("load_one_cycle", load_secret_o, 0);
        step(9);
        check("show_sec2", sec_left_o, 2);
        step(10);
        check("show_sec1", sec_left_o, 1);
        wait_screen(3'd2, 40);
        button_i   = 1'b1;
        guess_ok_i = 1'b1;
        push_exp(3'd3, 4, 3, 3, 1, 1);
        push_exp(3'd1, 30, 3, 3, 2, 1);
        push_exp(3'd2, 30, 10, 3, 2, 1);
        step(2);
        check("wait_before_press", sec_left_o, 10);
        step(1);
        check("check_one_cycle_sec", sec_left_o, 0);
        step(1);
        button_i = 1'b0;
        wait_screen(3'd2, 200);

        // Round 2: three wrong guesses -> LOSE.
        wrong_press(2);
        wrong_press(1);
        push_exp(3'd4, 16, 3, 0, 2, 1);
        push_exp(3'd1, 30, 3, 3, 3, 1);
        push_exp(3'd2, 30, 10, 3, 3, 1);
        wrong_press(0);
        wait_screen(3'd2, 200);

        // Round 3: timeout, then a press landing on the final tick.
        step(50);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        step(48);
        check("timeout_last_sec", sec_left_o, 1);
        check("timeout_tries_before", tries_left_o, 3);
        step(1);
        check("timeout_tries_after", tries_left_o, 2);
        check("timeout_sec_reload", sec_left_o, 10);
        check("timeout_stays_wait", screen_o, 2);
        step(97);
        button_i   = 1'b1;
        guess_ok_i = 1'b1;
        push_exp(3'd3, 201, 3, 2, 3, 2);
        push_exp(3'd1, 30, 3, 3, 4, 2);
        push_exp(3'd2, 30, 10, 3, 4, 2);
        step(2);
        check("final_tick_sec", sec_left_o, 1);
        step(1);
        check("final_tick_check_screen", screen_o, 2);
        check("final_tick_no_decrement", tries_left_o, 2);
        button_i = 1'b0;
        wait_screen(3'd3, 5);
        wait_screen(3'd2, 200);

        win_round(4, 3, 1'b0);
        win_round(5, 4, 1'b1);
        check("over_game_over", game_over_o, 1);
        check("over_busy", busy_o, 0);
        step(5);
        check("over_hold_score", score_o, 4);

        // Game 2: restart from OVER and win every round.
        start_i = 1'b1;
        push_exp(3'd1, -1, 3, 3, 1, 0);
        push_exp(3'd2, 30, 10, 3, 1, 0);
        step(1);
        start_i = 1'b0;
        check("restart_score", score_o, 0);
        check("restart_round", round_num_o, 1);
        wait_screen(3'd2, 40);
        for (int r = 1; r <= 5; r++) win_round(r, r, r == 5);
        check("g2_score", score_o, 5);
        check("g2_game_over", game_over_o, 1);
        check("g2_busy", busy_o, 0);

        // Game 3: button outside WAIT_IN ignored, held button gives one press, reset mid-round.
        start_i = 1'b1;
        push_exp(3'd1, -1, 3, 3, 1, 0);
        push_exp(3'd2, 30, 10, 3, 1, 0);
        step(1);
        start_i = 1'b0;
        step(5);
        button_i = 1'b1;
        step(4);
        button_i = 1'b0;
        wait_screen(3'd2, 40);
        step(20);
        check("no_queued_press_screen", screen_o, 2);
        check("no_queued_press_tries", tries_left_o, 3);
        check("no_queued_press_sec", sec_left_o, 8);
        button_i   = 1'b1;
        guess_ok_i = 1'b0;
        step(30);
        check("held_single_press_tries", tries_left_o, 2);
        check("held_single_press_sec", sec_left_o, 8);
        check("held_single_press_screen", screen_o, 2);
        check("sb_all_consumed", exp_q.size(), 0);
        mon_en = 1'b0;
        reset  = 1'b1;
        step(1);
        check_reset_vals();
        step(2);
        reset = 1'b0;
        step(5);
        button_i = 1'b0;
        step(5);
        check("idle_after_reset", screen_o, 0);
        mon_en = 1'b1;
        step(1);
        start_i = 1'b1;
        push_exp(3'd1, -1, 3, 3, 1, 0);
        push_exp(3'd2, 30, 10, 3, 1, 0);
        step(1);
        start_i = 1'b0;
        wait_screen(3'd2, 40);
        step(15);
        check("no_spurious_press_screen", screen_o, 2);
        check("no_spurious_press_tries", tries_left_o, 3);
        check("no_spurious_press_sec", sec_left_o, 9);
        check("sb_all_consumed_end", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
